// File: rtl/vx_alu_issue_arb_pkg.sv
// Shared widths, helpers and request bundle for the ALU issue arbiter.
package VX_gpu_pkg;

   localparam int ALU_ARB_NUM_REQS  = 4;
   localparam int ALU_ARB_DATAW     = 128;
   localparam int ALU_ARB_NUM_WARPS = 4;

   function automatic int up_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int ALU_ARB_SEL_W = up_clog2(ALU_ARB_NUM_REQS);
   localparam int NW_W          = up_clog2(ALU_ARB_NUM_WARPS);

   typedef struct packed {
      logic [ALU_ARB_DATAW-1:0] data;
      logic [NW_W-1:0]          wid;
      logic                     is_br;
   } alu_arb_req_t;

endpackage

// File: rtl/vx_alu_issue_arb_rr.sv
// Round-robin grant: first request at or after the pointer, cyclic.
module vx_rr_arbiter
   import VX_gpu_pkg::*;
#(
   parameter  int NUM_REQS = 4,
   localparam int SEL_W    = up_clog2(NUM_REQS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_REQS-1:0] i_req,
   output logic [NUM_REQS-1:0] o_gnt,
   output logic [SEL_W-1:0]    o_gnt_idx,
   output logic                o_gnt_vld
);

   logic [SEL_W-1:0] r_ptr;
   int               w_j;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_gnt_vld = 1'b0;
      w_j       = 0;
      for (int k = 0; k < NUM_REQS; k++) begin
         w_j = (int'(r_ptr) + k) % NUM_REQS;
         if (!o_gnt_vld && i_req[w_j]) begin
            o_gnt_vld  = 1'b1;
            o_gnt[w_j] = 1'b1;
            o_gnt_idx  = SEL_W'(w_j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_ptr <= '0;
      else if (o_gnt_vld)
         r_ptr <= (int'(o_gnt_idx) == NUM_REQS - 1) ? '0 : o_gnt_idx + SEL_W'(1);
   end

endmodule

// File: rtl/vx_alu_issue_arb.sv
// Shares one ALU execute port among issue slots with credit and
// per-warp branch throttling behind a one-entry output register.
module vx_alu_issue_arb
   import VX_gpu_pkg::*;
#(
   parameter  int NUM_REQS        = ALU_ARB_NUM_REQS,
   parameter  int DATAW           = ALU_ARB_DATAW,
   parameter  int NUM_WARPS       = ALU_ARB_NUM_WARPS,
   parameter  int MAX_OUTSTANDING = 4,
   localparam int SEL_W           = up_clog2(NUM_REQS),
   localparam int WID_W           = up_clog2(NUM_WARPS),
   localparam int CNT_W           = up_clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       req_valid,
   input  logic [NUM_REQS*DATAW-1:0] req_data,
   input  logic [NUM_REQS*WID_W-1:0] req_wid,
   input  logic [NUM_REQS-1:0]       req_is_br,
   output logic [NUM_REQS-1:0]       req_ready,
   output logic                      alu_valid,
   output logic [DATAW-1:0]          alu_data,
   output logic [SEL_W-1:0]          alu_sel,
   input  logic                      alu_ready,
   input  logic                      commit_fire,
   input  logic                      br_valid,
   input  logic [WID_W-1:0]          br_wid,
   output logic [NUM_WARPS-1:0]      br_pending
);

   typedef struct packed {
      logic [DATAW-1:0] data;
      logic [WID_W-1:0] wid;
      logic             is_br;
   } req_t;

   req_t [NUM_REQS-1:0] w_req;
   req_t                w_win;
   logic [NUM_REQS-1:0] w_elig;
   logic [NUM_REQS-1:0] w_gnt;
   logic [SEL_W-1:0]    w_gnt_idx;
   logic                w_gnt_vld;
   logic                w_credit_ok;
   logic                w_slot_free;
   logic                w_inc;
   logic                w_dec;

   logic                 r_valid;
   logic [DATAW-1:0]     r_data;
   logic [SEL_W-1:0]     r_sel;
   logic [CNT_W-1:0]     r_count;
   logic [NUM_WARPS-1:0] r_pend;
   logic [NUM_WARPS-1:0] w_pend_nxt;

   always_comb begin
      for (int i = 0; i < NUM_REQS; i++) begin
         w_req[i].data  = req_data[i*DATAW +: DATAW];
         w_req[i].wid   = req_wid[i*WID_W +: WID_W];
         w_req[i].is_br = req_is_br[i];
      end
   end

   // The held op still counts against credit until the ALU takes it.
   assign w_credit_ok = ({1'b0, r_count} + {{CNT_W{1'b0}}, r_valid})
                        < (CNT_W+1)'(MAX_OUTSTANDING);
   assign w_slot_free = !r_valid || alu_ready;

   always_comb begin
      for (int i = 0; i < NUM_REQS; i++)
         w_elig[i] = req_valid[i] && !r_pend[w_req[i].wid]
                     && w_credit_ok && w_slot_free && !reset;
   end

   vx_rr_arbiter #(
      .NUM_REQS (NUM_REQS)
   ) u_rr (
      .clk       (clk),
      .reset     (reset),
      .i_req     (w_elig),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_gnt_vld (w_gnt_vld)
   );

   assign w_win = w_req[w_gnt_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
      end else if (w_gnt_vld) begin
         r_valid <= 1'b1;
         r_data  <= w_win.data;
         r_sel   <= w_gnt_idx;
      end else if (alu_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign w_inc = r_valid && alu_ready;
   assign w_dec = commit_fire;

   always_ff @(posedge clk) begin
      if (reset)
         r_count <= '0;
      else if (w_inc && !w_dec)
         r_count <= r_count + CNT_W'(1);
      else if (!w_inc && w_dec)
         r_count <= r_count - CNT_W'(1);
   end

   // A new branch from the resolving warp overrides the clear.
   always_comb begin
      w_pend_nxt = r_pend;
      if (br_valid)
         w_pend_nxt[br_wid] = 1'b0;
      if (w_gnt_vld && w_win.is_br)
         w_pend_nxt[w_win.wid] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_pend <= '0;
      else
         r_pend <= w_pend_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(commit_fire && r_count == '0))
            else $error("commit_fire with no ops outstanding");
         assert (!(br_valid && !r_pend[br_wid]))
            else $warning("br_valid for warp with no pending branch");
      end
   end

   assign req_ready  = w_gnt;
   assign alu_valid  = r_valid;
   assign alu_data   = r_data;
   assign alu_sel    = r_sel;
   assign br_pending = r_pend;

endmodule

// File: tb/tb_vx_alu_issue_arb.sv
// Directed bench for vx_alu_issue_arb: fairness, credit, stall,
// branch serialisation and mid-operation reset.
module tb_vx_alu_issue_arb;

   localparam int NR  = 4;
   localparam int DW  = 128;
   localparam int NWP = 4;
   localparam int NWW = 2;
   localparam int SW  = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [NR-1:0]   req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR*NWW-1:0] req_wid;
   logic [NR-1:0]   req_is_br;
   logic [NR-1:0]   req_ready;
   logic            alu_valid;
   logic [DW-1:0]   alu_data;
   logic [SW-1:0]   alu_sel;
   logic            alu_ready;
   logic            commit_fire;
   logic            br_valid;
   logic [NWW-1:0]  br_wid;
   logic [NWP-1:0]  br_pending;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vx_alu_issue_arb #(
      .NUM_REQS        (NR),
      .DATAW           (DW),
      .NUM_WARPS       (NWP),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_wid     (req_wid),
      .req_is_br   (req_is_br),
      .req_ready   (req_ready),
      .alu_valid   (alu_valid),
      .alu_data    (alu_data),
      .alu_sel     (alu_sel),
      .alu_ready   (alu_ready),
      .commit_fire (commit_fire),
      .br_valid    (br_valid),
      .br_wid      (br_wid),
      .br_pending  (br_pending)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] w, input logic b);
      req_wid[i*NWW +: NWW] = w;
      req_is_br[i]          = b;
   endtask

   initial begin
      reset       = 1'b1;
      req_valid   = 4'hF;
      req_wid     = '0;
      req_is_br   = '0;
      alu_ready   = 1'b1;
      commit_fire = 1'b0;
      br_valid    = 1'b0;
      br_wid      = '0;
      for (int i = 0; i < NR; i++)
         req_data[i*DW +: DW] = 128'hD000 + 128'(i);

      @(negedge clk);
      chk("rst_ready", 128'(req_ready), 0);
      tick();
      tick();
      chk("rst_valid", 128'(alu_valid), 0);
      chk("rst_data", alu_data, 0);
      chk("rst_sel", 128'(alu_sel), 0);
      chk("rst_pend", 128'(br_pending), 0);

      // round robin, commit two cycles after each transfer
      reset = 1'b0;
      for (int c = 0; c < 11; c++) begin
         req_valid   = (c < 8) ? 4'hF : 4'h0;
         commit_fire = (c >= 3);
         @(negedge clk);
         if (c < 8)
            chk($sformatf("rr_ready%0d", c), 128'(req_ready),
                128'(1) << (c % 4));
         if (c >= 1 && c <= 8) begin
            chk($sformatf("rr_valid%0d", c), 128'(alu_valid), 1);
            chk($sformatf("rr_sel%0d", c), 128'(alu_sel), 128'((c - 1) % 4));
         end
         tick();
      end

      // credit limit, then one commit admits one more
      for (int c = 0; c < 14; c++) begin
         req_valid   = (c < 10) ? 4'hF : 4'h0;
         commit_fire = (c == 6) || (c >= 10);
         @(negedge clk);
         chk($sformatf("cr_ready%0d", c), 128'(req_ready),
             (c < 4) ? (128'(1) << c) : ((c == 7) ? 128'(1) : 128'(0)));
         tick();
      end
      commit_fire = 1'b0;

      // output stall
      req_valid = 4'hF;
      alu_ready = 1'b0;
      @(negedge clk);
      chk("st_ready0", 128'(req_ready), 4'b0010);
      tick();
      for (int c = 1; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("st_ready%0d", c), 128'(req_ready), 0);
         chk($sformatf("st_sel%0d", c), 128'(alu_sel), 1);
         chk($sformatf("st_data%0d", c), alu_data, 128'hD001);
         tick();
      end
      alu_ready = 1'b1;
      @(negedge clk);
      chk("st_release", 128'(req_ready), 4'b0100);
      tick();
      req_valid = 4'h0;
      @(negedge clk);
      chk("st_sel_next", 128'(alu_sel), 2);
      chk("st_data_next", alu_data, 128'hD002);
      tick();
      commit_fire = 1'b1;
      @(negedge clk);
      chk("st_drained", 128'(alu_valid), 0);
      tick();
      tick();
      commit_fire = 1'b0;

      // branch serialisation
      set_req(1, 2'd2, 1'b1);
      req_valid = 4'b0010;
      @(negedge clk);
      chk("br_grant", 128'(req_ready), 4'b0010);
      tick();
      set_req(1, 2'd2, 1'b0);
      set_req(2, 2'd3, 1'b0);
      req_valid = 4'b0110;
      @(negedge clk);
      chk("br_pend_set", 128'(br_pending), 4'b0100);
      chk("br_blocked", 128'(req_ready), 4'b0100);
      tick();
      req_valid = 4'b0010;
      br_valid  = 1'b1;
      br_wid    = 2'd2;
      @(negedge clk);
      chk("br_resolve_cyc", 128'(req_ready), 0);
      tick();
      br_valid = 1'b0;
      @(negedge clk);
      chk("br_pend_clr", 128'(br_pending), 0);
      chk("br_unblocked", 128'(req_ready), 4'b0010);
      tick();
      req_valid   = 4'h0;
      commit_fire = 1'b1;
      tick();
      tick();
      tick();
      commit_fire = 1'b0;

      // set beats clear for the same warp
      set_req(0, 2'd1, 1'b1);
      req_valid = 4'b0001;
      br_valid  = 1'b1;
      br_wid    = 2'd1;
      @(negedge clk);
      chk("sc_grant", 128'(req_ready), 4'b0001);
      tick();
      req_valid = 4'h0;
      br_valid  = 1'b0;
      @(negedge clk);
      chk("sc_pend", 128'(br_pending), 4'b0010);
      tick();

      // build up state, then reset mid-operation
      set_req(1, 2'd0, 1'b0);
      req_valid = 4'b0010;
      @(negedge clk);
      chk("mr_grant1", 128'(req_ready), 4'b0010);
      tick();
      set_req(2, 2'd3, 1'b1);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("mr_grant2", 128'(req_ready), 4'b0100);
      tick();
      set_req(2, 2'd0, 1'b0);
      @(negedge clk);
      chk("mr_grant3", 128'(req_ready), 4'b0100);
      tick();
      alu_ready = 1'b0;
      req_valid = 4'h0;
      @(negedge clk);
      chk("mr_held", 128'(alu_valid), 1);
      chk("mr_pend", 128'(br_pending), 4'b1010);
      reset     = 1'b1;
      req_valid = 4'hF;
      #1;
      chk("mr_rst_ready", 128'(req_ready), 0);
      tick();
      reset     = 1'b0;
      alu_ready = 1'b1;
      for (int i = 0; i < NR; i++)
         set_req(i, 2'd0, 1'b0);
      chk("mr_valid", 128'(alu_valid), 0);
      chk("mr_data", alu_data, 0);
      chk("mr_sel", 128'(alu_sel), 0);
      chk("mr_pend_clr", 128'(br_pending), 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("mr_ready%0d", c), 128'(req_ready),
             (c < 4) ? (128'(1) << c) : 128'(0));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
